// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read/write burst engines: FSM states and
// AXI4 protocol constants.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } dma_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_MAX_BURST  = 256;

endpackage

// File: rtl/axi_dma_rd_if.sv
// AXI4 read-address and read-data channels between the DMA read engine
// (master) and the DRAM-side port (slave).
interface axi_dma_rd_if #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 64,
    parameter int AXI_WIDTH_ID = 4
);
    logic [AXI_WIDTH_ID-1:0] arid;
    logic [AXI_WIDTH_AD-1:0] araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [AXI_WIDTH_ID-1:0] rid;
    logic [AXI_WIDTH_DA-1:0] rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_dma_rd.sv
// DMA read-burst engine: turns one command pulse into one AXI4 INCR read
// burst and streams the returned beats straight through to the consumer.
module axi_dma_rd
    import dma_pkg::*;
#(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 64,
    parameter int AXI_WIDTH_ID = 4,
    parameter int BIT_TRANS    = 18,
    parameter int AXI_ARID     = 0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_ctrl_read,
    input  logic [AXI_WIDTH_AD-1:0] i_read_addr,
    input  logic [BIT_TRANS-1:0]    i_num_trans,
    output logic                    o_read_done,
    output logic                    o_rd_busy,
    output logic                    o_rd_err,
    input  logic                    i_err_clr,
    output logic [AXI_WIDTH_DA-1:0] o_data,
    output logic                    o_data_valid,
    input  logic                    i_data_ready,
    output logic [BIT_TRANS-1:0]    o_data_cnt,
    axi_dma_rd_if.master            m_axi
);

    localparam logic [BIT_TRANS-1:0] ONE     = BIT_TRANS'(1);
    localparam logic [BIT_TRANS-1:0] MAX_LEN = BIT_TRANS'(AXI_MAX_BURST);

    dma_state_t              state;
    logic [AXI_WIDTH_AD-1:0] addr_q;
    logic [BIT_TRANS-1:0]    len_m1_q;
    logic [BIT_TRANS-1:0]    beat_cnt;
    logic                    ar_valid_q;
    logic                    done_q;
    logic                    err_q;

    logic in_data;
    logic cmd_ok;
    logic rd_fire;
    logic last_beat;
    logic err_set;

    assign in_data   = (state == ST_DATA);
    assign cmd_ok    = (i_num_trans != '0) && (i_num_trans <= MAX_LEN);
    assign rd_fire   = in_data && m_axi.rvalid && i_data_ready;
    assign last_beat = (beat_cnt == len_m1_q);

    // RLAST must coincide exactly with the final beat index; either mismatch is an error.
    assign err_set = (i_ctrl_read && (state != ST_IDLE))
                   || (i_ctrl_read && (state == ST_IDLE) && !cmd_ok)
                   || (rd_fire && ((m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rlast != last_beat)));

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values and block ordering cannot change behaviour.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            len_m1_q   <= '0;
            beat_cnt   <= '0;
            ar_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_ctrl_read && cmd_ok) begin
                        addr_q     <= i_read_addr;
                        len_m1_q   <= i_num_trans - ONE;
                        ar_valid_q <= 1'b1;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi.arready) begin
                        ar_valid_q <= 1'b0;
                        beat_cnt   <= '0;
                        state      <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rd_fire) begin
                        beat_cnt <= beat_cnt + ONE;
                        if (last_beat) begin
                            done_q <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error: a new error in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (i_err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign m_axi.arid    = AXI_WIDTH_ID'(AXI_ARID);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_m1_q[7:0];
    assign m_axi.arsize  = 3'($clog2(AXI_WIDTH_DA / 8));
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arvalid = ar_valid_q;
    assign m_axi.rready  = in_data && i_data_ready;

    assign o_data       = in_data ? m_axi.rdata : '0;
    assign o_data_valid = in_data && m_axi.rvalid;
    assign o_data_cnt   = beat_cnt;
    assign o_read_done  = done_q;
    assign o_rd_busy    = (state != ST_IDLE);
    assign o_rd_err     = err_q;

endmodule

// File: tb/tb_axi_dma_rd.sv
// Directed bench for axi_dma_rd: a table of bursts plus hand-written
// sequences for bad commands, busy commands and reset in the middle of a burst.
module tb_axi_dma_rd;

    localparam int AD = 32;
    localparam int DA = 64;
    localparam int IDW = 4;
    localparam int BT = 18;

    typedef struct {
        logic [31:0] addr;
        int          n;
        int          exp_arlen;
        int          err_beat;
        int          last_idx;
        logic [3:0]  ready_pat;
        int          stall;
        logic        exp_err;
    } burst_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_ctrl_read = 1'b0;
    logic [AD-1:0] i_read_addr = '0;
    logic [BT-1:0] i_num_trans = '0;
    logic          o_read_done;
    logic          o_rd_busy;
    logic          o_rd_err;
    logic          i_err_clr = 1'b0;
    logic [DA-1:0] o_data;
    logic          o_data_valid;
    logic          i_data_ready = 1'b0;
    logic [BT-1:0] o_data_cnt;

    int checks = 0;
    int failures = 0;
    int ar_hs = 0;

    axi_dma_rd_if #(.AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA), .AXI_WIDTH_ID(IDW)) axi ();

    axi_dma_rd #(
        .AXI_WIDTH_AD(AD), .AXI_WIDTH_DA(DA), .AXI_WIDTH_ID(IDW),
        .BIT_TRANS(BT), .AXI_ARID(0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_ctrl_read (i_ctrl_read),
        .i_read_addr (i_read_addr),
        .i_num_trans (i_num_trans),
        .o_read_done (o_read_done),
        .o_rd_busy   (o_rd_busy),
        .o_rd_err    (o_rd_err),
        .i_err_clr   (i_err_clr),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .i_data_ready(i_data_ready),
        .o_data_cnt  (o_data_cnt),
        .m_axi       (axi.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (axi.arvalid && axi.arready) ar_hs <= ar_hs + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_bus();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rlast   = 1'b0;
        axi.rresp   = 2'b00;
        axi.rdata   = '0;
        axi.rid     = '0;
    endtask

    task automatic run_burst(input burst_t v);
        int hs0;
        int b;
        int cyc;
        logic rdy;
        hs0 = ar_hs;
        @(negedge clk);
        i_ctrl_read = 1'b1;
        i_read_addr = v.addr;
        i_num_trans = BT'(v.n);
        axi.arready = 1'b0;
        #1 check("busy_before_cmd", o_rd_busy, 0);
        @(negedge clk);
        i_ctrl_read = 1'b0;
        for (int k = 0; k <= v.stall; k++) begin
            if (k > 0) @(negedge clk);
            axi.arready = (k == v.stall);
            #1;
            check("arvalid", axi.arvalid, 1);
            check("araddr", axi.araddr, v.addr);
            check("arlen", axi.arlen, v.exp_arlen);
            if (k == 0) begin
                check("arsize", axi.arsize, 3);
                check("arburst", axi.arburst, 1);
                check("arid", axi.arid, 0);
                check("busy_addr", o_rd_busy, 1);
            end
        end
        b = 0;
        cyc = 0;
        while (b < v.n && cyc < 2000) begin
            @(negedge clk);
            axi.arready  = 1'b0;
            axi.rvalid   = 1'b1;
            axi.rdata    = 64'h1111_0000_0000_0000 + 64'(b);
            axi.rresp    = (b == v.err_beat) ? 2'b10 : 2'b00;
            axi.rlast    = (b == v.last_idx);
            rdy          = v.ready_pat[cyc % 4];
            i_data_ready = rdy;
            #1;
            check("rready_mirror", axi.rready, rdy);
            check("data_valid", o_data_valid, 1);
            check("data", o_data, 64'h1111_0000_0000_0000 + 64'(b));
            check("data_cnt", o_data_cnt, b);
            check("no_early_done", o_read_done, 0);
            if (rdy) b++;
            cyc++;
        end
        if (b < v.n) check("beat_timeout", b, v.n);
        @(negedge clk);
        idle_bus();
        i_data_ready = 1'b1;
        #1;
        check("done_pulse", o_read_done, 1);
        check("busy_done", o_rd_busy, 1);
        @(negedge clk);
        #1;
        check("done_one_cycle", o_read_done, 0);
        check("busy_after", o_rd_busy, 0);
        check("rd_err", o_rd_err, v.exp_err);
        check("ar_handshakes", ar_hs - hs0, 1);
        if (v.exp_err) begin
            i_err_clr = 1'b1;
            @(negedge clk);
            i_err_clr = 1'b0;
            #1 check("err_cleared", o_rd_err, 0);
        end
    endtask

    burst_t vec[7];
    burst_t post_rst;

    initial begin
        // addr, n, exp_arlen, err_beat, last_idx, ready_pat, stall, exp_err
        vec[0] = '{32'h1000_0040,   8,   7, -1,   7, 4'b1111, 0, 1'b0}; // basic
        vec[1] = '{32'h1000_0080,   8,   7, -1,   7, 4'b1111, 5, 1'b0}; // AR stall
        vec[2] = '{32'h1000_00C0,   8,   7, -1,   7, 4'b1001, 0, 1'b0}; // backpressure 1,0,0,1
        vec[3] = '{32'h2000_0000,   8,   7,  3,   7, 4'b1111, 0, 1'b1}; // SLVERR on beat 3
        vec[4] = '{32'h2000_0040,   8,   7, -1,   5, 4'b1111, 0, 1'b1}; // early RLAST
        vec[5] = '{32'h3000_0000,   1,   0, -1,   0, 4'b1111, 1, 1'b0}; // single beat
        vec[6] = '{32'h3000_1000, 256, 255, -1, 255, 4'b1111, 0, 1'b0}; // max burst

        idle_bus();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_done", o_read_done, 0);
        check("rst_busy", o_rd_busy, 0);
        check("rst_err", o_rd_err, 0);
        check("rst_data_valid", o_data_valid, 0);
        check("rst_data_cnt", o_data_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) run_burst(vec[i]);

        // Illegal lengths: error, no burst.
        @(negedge clk);
        i_ctrl_read = 1'b1;
        i_num_trans = BT'(0);
        @(negedge clk);
        i_ctrl_read = 1'b0;
        #1;
        check("len0_err", o_rd_err, 1);
        check("len0_busy", o_rd_busy, 0);
        check("len0_arvalid", axi.arvalid, 0);
        @(negedge clk);
        i_ctrl_read = 1'b1;
        i_num_trans = BT'(257);
        i_err_clr   = 1'b1;
        @(negedge clk);
        i_ctrl_read = 1'b0;
        i_err_clr   = 1'b0;
        #1;
        check("set_wins_over_clr", o_rd_err, 1);
        check("len257_busy", o_rd_busy, 0);
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
        #1 check("err_clr_idle", o_rd_err, 0);

        // Command while busy, then reset in the middle of the data phase.
        @(negedge clk);
        i_ctrl_read = 1'b1;
        i_read_addr = 32'h4000_0000;
        i_num_trans = BT'(8);
        @(negedge clk);
        i_read_addr = 32'h5000_0000;
        i_num_trans = BT'(4);
        @(negedge clk);
        i_ctrl_read = 1'b0;
        #1;
        check("busy_cmd_err", o_rd_err, 1);
        check("busy_cmd_araddr", axi.araddr, 32'h4000_0000);
        check("busy_cmd_arlen", axi.arlen, 7);
        axi.arready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            axi.arready  = 1'b0;
            axi.rvalid   = 1'b1;
            axi.rdata    = 64'(b);
            i_data_ready = 1'b1;
            #1 check("pre_rst_cnt", o_data_cnt, b);
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midrst_busy", o_rd_busy, 0);
        check("midrst_arvalid", axi.arvalid, 0);
        check("midrst_rready", axi.rready, 0);
        check("midrst_data_valid", o_data_valid, 0);
        check("midrst_done", o_read_done, 0);
        check("midrst_err", o_rd_err, 0);
        check("midrst_cnt", o_data_cnt, 0);
        @(negedge clk);
        idle_bus();
        rstn = 1'b1;
        post_rst = '{32'h4000_0100, 4, 3, -1, 3, 4'b1111, 0, 1'b0};
        run_burst(post_rst);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_dma_rd.md
Name: axi_dma_rd

Overview:
- Read-burst engine on the far side of the DMA controller's read plane.
- Takes one 1-cycle burst command (o_ctrl_read / o_read_addr from the controller) and issues one AXI4 INCR read burst.
- Streams the returned R beats to the consumer buffer with backpressure, then pulses read_done back to the controller.
- Sits between the DMA controller and the AXI master port toward DRAM.

Parameters:
- AXI_WIDTH_AD, 32, address width.
- AXI_WIDTH_DA, 64, data width; one beat = 8 bytes.
- AXI_WIDTH_ID, 4, ID width.
- BIT_TRANS, 18, width of transfer-count fields.
- AXI_ARID, 0, constant ARID driven on every burst.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_ctrl_read  in  1  burst start pulse from DMA controller
- i_read_addr  in  AXI_WIDTH_AD  burst byte address, sampled with i_ctrl_read
- i_num_trans  in  BIT_TRANS  beats per burst, legal 1..256, sampled with i_ctrl_read
- o_read_done  out  1  1-cycle pulse, burst complete
- o_rd_busy  out  1  burst in flight
- o_rd_err  out  1  sticky error flag
- i_err_clr  in  1  clears o_rd_err
- o_data  out  AXI_WIDTH_DA  beat data to consumer
- o_data_valid  out  1  beat valid
- i_data_ready  in  1  consumer accept
- o_data_cnt  out  BIT_TRANS  index of current beat within burst
- M_ARID/ARADDR/ARLEN[7:0]/ARSIZE[2:0]/ARBURST[1:0]/ARVALID  out  AR channel
- M_ARREADY  in  1
- M_RID/RDATA/RRESP[1:0]/RLAST/RVALID  in  R channel
- M_RREADY  out  1

Behaviour:
- Reset: all outputs 0; state IDLE; internal address, length and beat counter cleared.
- Reset mid-burst returns to IDLE immediately; no done pulse.
- Constant AR fields:
  - ARSIZE = log2(AXI_WIDTH_DA/8), i.e. 3.
  - ARBURST = 2'b01 (INCR).
  - ARID = AXI_ARID.
- IDLE: on i_ctrl_read, latch address, latch len = i_num_trans, go to ADDR.
  - i_num_trans==0 or >256: set o_rd_err, stay IDLE, no done pulse.
- ADDR:
  - ARVALID=1, ARADDR=latched address, ARLEN=len-1 (low 8 bits).
  - ARVALID first rises the cycle after i_ctrl_read.
  - ARVALID and ARADDR/ARLEN stay stable until M_ARREADY; ARVALID never drops early.
  - On the handshake, go to DATA and clear the beat counter.
- DATA:
  - Flow-through path: M_RREADY = i_data_ready, o_data_valid = M_RVALID, o_data = M_RDATA. This is zero-latency and combinational.
  - A beat is accepted when RVALID & RREADY; o_data_cnt then increments.
  - RRESP != OKAY on any accepted beat: set o_rd_err, keep draining.
  - RLAST on beat index != len-1: set o_rd_err.
  - Beat index len-1 accepted without RLAST: set o_rd_err, still treat it as last.
  - On last-beat acceptance, go to DONE.
- DONE: o_read_done=1 for exactly one cycle, then IDLE. Total: done pulse appears the cycle after the last beat handshake.
- o_rd_busy = (state != IDLE).
- i_ctrl_read while busy: ignored, sets o_rd_err. The controller never does this legally.
- o_rd_err is sticky until i_err_clr. If i_err_clr and a new error occur in the same cycle, set wins.
- 4 KB crossing is not checked here. The controller's 64 B block alignment keeps bursts of 8 beats legal.
- o_data_cnt holds its last value in IDLE and clears on the AR handshake.
- States: IDLE, ADDR, DATA, DONE; 2-bit encoding.

Decomposition:
- Shared package dma_pkg:
  - state localparams (IDLE/ADDR/DATA/DONE)
  - AXI_BURST_INCR, AXI_RESP_OKAY
  - AXI_MAX_BURST=256
  - also reused by a future axi_dma_wr.
- No sub-module. The R path is a direct flow-through; a skid buffer (axi_skid_buf) is optional later if timing requires, and is not part of this block.

Test Plan:
- Basic burst: i_ctrl_read with addr 0x1000_0040, num_trans 8; ARREADY immediate; 8 RVALID beats with ready=1 -> ARLEN=7, ARADDR=0x1000_0040, o_data_cnt 0..7, o_read_done exactly 1 cycle after beat 7, o_rd_err=0.
- AR stall: ARREADY held low 5 cycles -> ARVALID/ARADDR stable for all 6 cycles, one AR handshake only.
- Consumer backpressure: i_data_ready toggles 1,0,0,1 while RVALID=1 -> RREADY mirrors it, no beat lost or duplicated, data order preserved (incrementing pattern 0..7).
- Error response: beat 3 returns RRESP=2'b10 -> o_rd_err=1 sticky, burst still completes with done pulse; i_err_clr clears it.
- Early RLAST: num_trans 8, RLAST on beat 5 -> o_rd_err=1, engine waits for beat 7 before done.
- Reset mid-DATA: rstn low after beat 2 -> all outputs 0 within the reset cycle; a new 4-beat burst after release completes normally.
